prog_loader: RTL and testbench

//   Byte-stream program loader: the writer side of the instruction memory.

---
 rtl/prog_loader.sv | 119 +++++++++++
 tb/tb_prog_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: receives a length/payload/checksum byte frame and writes the
// payload into instruction memory, holding the CPU in reset until a good load.
module prog_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_wr_addr,
    output logic [7:0]        im_wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned       BYTE_W = 8;
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        BOOT = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t              state;
    logic [BYTE_W-1:0]   count;
    logic [BYTE_W-1:0]   sum;
    logic [ADDR_W-1:0]   addr;
    logic                accept;
    logic                len_bad;

    // Ready is a pure decode of the registered state, so it never glitches on inputs.
    assign in_ready = (state == LEN) || (state == DATA) || (state == CSUM);
    assign accept   = in_valid && in_ready;
    assign len_bad  = (in_data == '0) || (32'(in_data) > DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            count      <= '0;
            sum        <= '0;
            addr       <= BASE;
            im_wr_en   <= 1'b0;
            im_wr_addr <= BASE;
            im_wr_data <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            im_wr_en <= 1'b0;
            case (state)
                BOOT: state <= LEN;
                LEN: begin
                    if (accept) begin
                        if (len_bad) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            count <= in_data;
                            sum   <= '0;
                            addr  <= BASE;
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    // One write strobe per accepted payload byte, one cycle later.
                    if (accept) begin
                        im_wr_en   <= 1'b1;
                        im_wr_addr <= addr;
                        im_wr_data <= in_data;
                        sum        <= sum + in_data;
                        addr       <= addr + ADDR_W'(1);
                        count      <= count - BYTE_W'(1);
                        if (count == BYTE_W'(1)) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (in_data == sum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state    <= LEN;
                        done     <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                ERR: begin
                    if (start) begin
                        state <= LEN;
                        error <= 1'b0;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: three instances (default, DEPTH=4, BASE_ADDR=FE)
// share one input stream; each scenario resets and checks the relevant instance.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       start = 1'b0;

    logic       m_ready, m_wr_en, m_hold, m_done, m_error;
    logic [7:0] m_wr_addr, m_wr_data;
    logic       s_ready, s_wr_en, s_hold, s_done, s_error;
    logic [7:0] s_wr_addr, s_wr_data;
    logic       b_ready, b_wr_en, b_hold, b_done, b_error;
    logic [7:0] b_wr_addr, b_wr_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  d;
        logic [31:0] c;
    } wr_t;

    wr_t mq[$];
    wr_t sq[$];
    wr_t bq[$];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) u_main (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(m_ready), .start(start), .im_wr_en(m_wr_en),
        .im_wr_addr(m_wr_addr), .im_wr_data(m_wr_data), .cpu_hold(m_hold),
        .done(m_done), .error(m_error)
    );

    prog_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) u_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_ready), .start(start), .im_wr_en(s_wr_en),
        .im_wr_addr(s_wr_addr), .im_wr_data(s_wr_data), .cpu_hold(s_hold),
        .done(s_done), .error(s_error)
    );

    prog_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(254)) u_base (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_ready), .start(start), .im_wr_en(b_wr_en),
        .im_wr_addr(b_wr_addr), .im_wr_data(b_wr_data), .cpu_hold(b_hold),
        .done(b_done), .error(b_error)
    );

    always @(posedge clk) cyc++;

    // Record every memory write with the cycle it appeared in.
    always @(negedge clk) begin
        if (m_wr_en) mq.push_back({m_wr_addr, m_wr_data, 32'(cyc)});
        if (s_wr_en) sq.push_back({s_wr_addr, s_wr_data, 32'(cyc)});
        if (b_wr_en) bq.push_back({b_wr_addr, b_wr_data, 32'(cyc)});
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        in_data = 8'h00;
        @(negedge clk);
        mq.delete();
        sq.delete();
        bq.delete();
        reset = 1'b0;
    endtask

    // Present one byte after `gap` idle cycles; returns at the negedge after it is taken.
    task automatic send(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data = b;
        t = 0;
        while (!m_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t == 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed %b for byte %h, want 1", m_ready, b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        #1;
        n_cmp++; if ({m_wr_en, m_hold, m_done, m_error, m_ready} !== 5'b01000) begin
            n_err++; $display("FAIL reset_flags: got en/hold/done/err/rdy=%b want 01000",
                              {m_wr_en, m_hold, m_done, m_error, m_ready});
        end
        n_cmp++; if ({m_wr_addr, m_wr_data} !== 16'h0000) begin
            n_err++; $display("FAIL reset_wr_bus: got %h want 0000", {m_wr_addr, m_wr_data});
        end
        n_cmp++; if (b_wr_addr !== 8'hFE) begin
            n_err++; $display("FAIL reset_base_addr: got %h want fe", b_wr_addr);
        end
        @(negedge clk);
        mq.delete(); sq.delete(); bq.delete();
        reset = 1'b0;
        #1;
        n_cmp++; if (m_ready !== 1'b0) begin
            n_err++; $display("FAIL boot_ready: got %b want 0", m_ready);
        end
        @(negedge clk);
        n_cmp++; if (m_ready !== 1'b1) begin
            n_err++; $display("FAIL len_ready: got %b want 1", m_ready);
        end
    endtask

    task automatic test_load_ok();
        logic [7:0] ea[3] = '{8'h00, 8'h01, 8'h02};
        logic [7:0] ed[3] = '{8'hA1, 8'hB2, 8'hC3};
        do_reset();
        send(8'h03, 0); send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 0); send(8'h16, 0);
        n_cmp++;
        if (mq.size() !== 3) begin
            n_err++; $display("FAIL ok_write_count: got %0d want 3", mq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if ({mq[i].a, mq[i].d} !== {ea[i], ed[i]}) begin
                    n_err++; $display("FAIL ok_write%0d: got %h/%h want %h/%h",
                                      i, mq[i].a, mq[i].d, ea[i], ed[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                n_cmp++; if (mq[i].c !== mq[i-1].c + 1) begin
                    n_err++; $display("FAIL ok_b2b%0d: got cycle %0d want %0d",
                                      i, mq[i].c, mq[i-1].c + 1);
                end
            end
        end
        n_cmp++; if ({m_done, m_hold, m_error, m_wr_en, m_ready} !== 5'b10000) begin
            n_err++; $display("FAIL ok_status: got done/hold/err/en/rdy=%b want 10000",
                              {m_done, m_hold, m_error, m_wr_en, m_ready});
        end
        pulse_start();
        n_cmp++; if ({m_done, m_hold, m_ready} !== 3'b011) begin
            n_err++; $display("FAIL ok_rearm: got done/hold/rdy=%b want 011",
                              {m_done, m_hold, m_ready});
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        send(8'h03, 0); send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 0); send(8'h17, 0);
        n_cmp++; if (mq.size() !== 3) begin
            n_err++; $display("FAIL csum_write_count: got %0d want 3", mq.size());
        end
        n_cmp++; if ({m_error, m_hold, m_done, m_ready} !== 4'b1100) begin
            n_err++; $display("FAIL csum_status: got err/hold/done/rdy=%b want 1100",
                              {m_error, m_hold, m_done, m_ready});
        end
        pulse_start();
        n_cmp++; if ({m_error, m_hold, m_ready} !== 3'b011) begin
            n_err++; $display("FAIL csum_rearm: got err/hold/rdy=%b want 011",
                              {m_error, m_hold, m_ready});
        end
    endtask

    task automatic test_bad_length();
        do_reset();
        send(8'h00, 0);
        n_cmp++; if ({m_error, m_done, m_hold, m_ready} !== 4'b1010) begin
            n_err++; $display("FAIL len0_status: got err/done/hold/rdy=%b want 1010",
                              {m_error, m_done, m_hold, m_ready});
        end
        repeat (2) @(negedge clk);
        n_cmp++; if (mq.size() !== 0) begin
            n_err++; $display("FAIL len0_writes: got %0d want 0", mq.size());
        end
        do_reset();
        send(8'h05, 0);
        n_cmp++; if ({s_error, s_ready} !== 2'b10) begin
            n_err++; $display("FAIL len5_small: got err/rdy=%b want 10", {s_error, s_ready});
        end
        n_cmp++; if ({m_error, m_ready} !== 2'b01) begin
            n_err++; $display("FAIL len5_main: got err/rdy=%b want 01", {m_error, m_ready});
        end
        n_cmp++; if (sq.size() !== 0) begin
            n_err++; $display("FAIL len5_writes: got %0d want 0", sq.size());
        end
    endtask

    task automatic test_stalls();
        do_reset();
        send(8'h02, 1); send(8'hFF, 3); send(8'h02, 0); send(8'h01, 2);
        n_cmp++;
        if (mq.size() !== 2) begin
            n_err++; $display("FAIL stall_write_count: got %0d want 2", mq.size());
        end else begin
            n_cmp++; if ({mq[0].a, mq[0].d, mq[1].a, mq[1].d} !== 32'h00FF_0102) begin
                n_err++; $display("FAIL stall_writes: got %h want 00ff0102",
                                  {mq[0].a, mq[0].d, mq[1].a, mq[1].d});
            end
        end
        n_cmp++; if ({m_done, m_error, m_hold} !== 3'b100) begin
            n_err++; $display("FAIL stall_status: got done/err/hold=%b want 100",
                              {m_done, m_error, m_hold});
        end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] ea[3] = '{8'hFE, 8'hFF, 8'h00};
        logic [7:0] ed[3] = '{8'h10, 8'h20, 8'h30};
        do_reset();
        send(8'h03, 0); send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h60, 0);
        n_cmp++;
        if (bq.size() !== 3) begin
            n_err++; $display("FAIL wrap_write_count: got %0d want 3", bq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if ({bq[i].a, bq[i].d} !== {ea[i], ed[i]}) begin
                    n_err++; $display("FAIL wrap_write%0d: got %h/%h want %h/%h",
                                      i, bq[i].a, bq[i].d, ea[i], ed[i]);
                end
            end
        end
        n_cmp++; if ({b_done, b_error, b_hold} !== 3'b100) begin
            n_err++; $display("FAIL wrap_status: got done/err/hold=%b want 100",
                              {b_done, b_error, b_hold});
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        send(8'h03, 0); send(8'hA1, 0); send(8'hB2, 0);
        n_cmp++; if ({m_wr_en, m_wr_addr, m_wr_data} !== {1'b1, 8'h01, 8'hB2}) begin
            n_err++; $display("FAIL mid_pre_write: got %b/%h/%h want 1/01/b2",
                              m_wr_en, m_wr_addr, m_wr_data);
        end
        reset = 1'b1;
        #1;
        n_cmp++; if ({m_wr_en, m_hold, m_ready, m_done, m_error} !== 5'b01000) begin
            n_err++; $display("FAIL mid_reset_out: got en/hold/rdy/done/err=%b want 01000",
                              {m_wr_en, m_hold, m_ready, m_done, m_error});
        end
        @(negedge clk);
        mq.delete(); sq.delete(); bq.delete();
        reset = 1'b0;
        #1;
        n_cmp++; if (m_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_boot_ready: got %b want 0", m_ready);
        end
        send(8'h03, 0); send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 0); send(8'h16, 0);
        n_cmp++;
        if (mq.size() !== 3) begin
            n_err++; $display("FAIL mid_write_count: got %0d want 3", mq.size());
        end else begin
            n_cmp++; if ({mq[0].a, mq[1].a, mq[2].a} !== 24'h00_01_02) begin
                n_err++; $display("FAIL mid_addrs: got %h want 000102",
                                  {mq[0].a, mq[1].a, mq[2].a});
            end
        end
        n_cmp++; if ({m_done, m_hold} !== 2'b10) begin
            n_err++; $display("FAIL mid_done: got done/hold=%b want 10", {m_done, m_hold});
        end
    endtask

    initial begin
        test_reset();
        test_load_ok();
        test_bad_checksum();
        test_bad_length();
        test_stalls();
        test_addr_wrap();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
